// File: rtl/sync_fifo_ctl.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctl
// Parametrised single-clock FIFO with count-based full/empty, so all DEPTH
// entries are usable and DEPTH need not be a power of two. Provides
// programmable almost-full/almost-empty thresholds, an occupancy count,
// one-cycle overflow/underflow pulses and an optional first-word-fall-through
// read mode.
//
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0; a read
// is taken when rd_en=1 and empty=0. A request made against a full (write) or
// empty (read) FIFO is dropped and reported by a one-cycle overflow/underflow
// pulse on the following cycle. In FWFT mode rd_en acknowledges the word
// already presented on dout.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   wr_en, din    write request and data
//   rd_en         read request (FWFT: acknowledge of head)
//   dout          read data
//   empty, full   count == 0 / count == DEPTH
//   almost_empty  count <= AE_LEVEL
//   almost_full   count >= AF_LEVEL
//   count         occupancy 0..DEPTH
//   overflow      pulse: write rejected because FIFO was full
//   underflow     pulse: read rejected because FIFO was empty
// ----------------------------------------------------------------------------
module sync_fifo_ctl #(
    parameter int DWIDTH   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DWIDTH-1:0]          din,
    input  logic                       rd_en,
    output logic [DWIDTH-1:0]          dout,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              wa;
    logic              ra;

    // Wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Flags depend only on the registered count.
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_empty = (count <= CW'(AE_LEVEL));
    assign almost_full  = (count >= CW'(AF_LEVEL));

    assign wa = wr_en & ~full;
    assign ra = rd_en & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wa) wptr <= ptr_next(wptr);
            if (ra) rptr <= ptr_next(rptr);
            case ({wa, ra})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

    // Storage is not reset; stale contents are never visible because the
    // pointers and count are.
    always_ff @(posedge clk) begin
        if (wa) mem[wptr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word presented straight from the array.
            assign dout = mem[rptr];
        end else begin : g_std
            logic [DWIDTH-1:0] dout_r;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     dout_r <= '0;
                else if (ra) dout_r <= mem[rptr];
            end
            assign dout = dout_r;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_ctl
// Directed bench for sync_fifo_ctl. Three instances share clock, reset and
// request inputs:
//   u_d8 : DEPTH=8, AF=6, AE=2, registered read (table-driven checks)
//   u_d5 : DEPTH=5, registered read (pointer wrap sequence)
//   u_fw : DEPTH=8, FWFT=1 (fall-through sequence)
// ----------------------------------------------------------------------------
module tb_sync_fifo_ctl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] din   = '0;

    logic [15:0] dout8, dout5, doutf;
    logic        empty8, full8, ae8, af8, ov8, un8;
    logic        empty5, full5, ae5, af5, ov5, un5;
    logic        emptyf, fullf, aef, aff, ovf, unf;
    logic [3:0]  count8, countf;
    logic [2:0]  count5;

    sync_fifo_ctl #(.DWIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_d8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout8), .empty(empty8), .full(full8), .almost_empty(ae8),
        .almost_full(af8), .count(count8), .overflow(ov8), .underflow(un8)
    );

    sync_fifo_ctl #(.DWIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d5 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout5), .empty(empty5), .full(full5), .almost_empty(ae5),
        .almost_full(af5), .count(count5), .overflow(ov5), .underflow(un5)
    );

    sync_fifo_ctl #(.DWIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(doutf), .empty(emptyf), .full(fullf), .almost_empty(aef),
        .almost_full(aff), .count(countf), .overflow(ovf), .underflow(unf)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [15:0] dout;
        int          cnt;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic rd, input logic [15:0] d,
                                input logic [15:0] q, input int cnt,
                                input logic ov, input logic un);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = d; v.dout = q; v.cnt = cnt; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic wr, input logic rd, input logic [15:0] d);
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        // Fill/drain with threshold stepping 0->8->0.
        for (int k = 1; k <= 8; k++) add(1, 0, 16'(k), 16'h0000, k, 0, 0);
        add(1, 0, 16'h0009, 16'h0000, 8, 1, 0);          // write at full
        add(0, 0, 16'h0000, 16'h0000, 8, 0, 0);          // overflow drops
        for (int k = 1; k <= 8; k++) add(0, 1, 16'h0000, 16'(k), 8 - k, 0, 0);
        // Simultaneous read/write at count 3.
        add(1, 0, 16'h0011, 16'h0008, 1, 0, 0);
        add(1, 0, 16'h0012, 16'h0008, 2, 0, 0);
        add(1, 0, 16'h0013, 16'h0008, 3, 0, 0);
        for (int k = 0; k < 4; k++) add(1, 1, 16'h0014 + 16'(k), 16'h0011 + 16'(k), 3, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 16'h0000, 16'h0015 + 16'(k), 2 - k, 0, 0);
        // Both at empty: write wins, read rejected.
        add(1, 1, 16'h0020, 16'h0017, 1, 0, 1);
        add(0, 1, 16'h0000, 16'h0020, 0, 0, 0);
        add(0, 1, 16'h0000, 16'h0020, 0, 0, 1);          // read at empty
        add(0, 0, 16'h0000, 16'h0020, 0, 0, 0);
        // Both at full: read wins, write rejected.
        for (int k = 0; k < 8; k++) add(1, 0, 16'h0030 + 16'(k), 16'h0020, k + 1, 0, 0);
        add(1, 1, 16'h0040, 16'h0030, 7, 1, 0);
        add(0, 0, 16'h0000, 16'h0030, 7, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 1, 16'h0000, 16'h0030 + 16'(k), 7 - k, 0, 0);

        // Reset state, checked while rst is still asserted before any edge.
        #1;
        chk("rst_empty", 32'(empty8), 32'd1);
        chk("rst_count", 32'(count8), 32'd0);
        chk("rst_full",  32'(full8),  32'd0);
        chk("rst_ae",    32'(ae8),    32'd1);
        chk("rst_af",    32'(af8),    32'd0);
        chk("rst_dout",  32'(dout8),  32'd0);
        chk("rst_ov",    32'(ov8),    32'd0);
        chk("rst_un",    32'(un8),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk($sformatf("v%0d_count", i), 32'(count8), 32'(vecs[i].cnt));
            chk($sformatf("v%0d_empty", i), 32'(empty8), 32'(vecs[i].cnt == 0));
            chk($sformatf("v%0d_full", i),  32'(full8),  32'(vecs[i].cnt == 8));
            chk($sformatf("v%0d_ae", i),    32'(ae8),    32'(vecs[i].cnt <= 2));
            chk($sformatf("v%0d_af", i),    32'(af8),    32'(vecs[i].cnt >= 6));
            chk($sformatf("v%0d_ov", i),    32'(ov8),    32'(vecs[i].ov));
            chk($sformatf("v%0d_un", i),    32'(un8),    32'(vecs[i].un));
            chk($sformatf("v%0d_dout", i),  32'(dout8),  32'(vecs[i].dout));
        end

        // Asynchronous reset mid-cycle with data present and dout nonzero.
        drive(1, 0, 16'h0055);
        chk("t1_pre_count", 32'(count8), 32'd1);
        chk("t1_pre_dout",  32'(dout8),  32'h37);
        #1;
        wr_en = 1'b0;
        rst   = 1'b1;
        #1;
        chk("t1_empty", 32'(empty8), 32'd1);
        chk("t1_count", 32'(count8), 32'd0);
        chk("t1_dout",  32'(dout8),  32'd0);
        chk("t1_ae",    32'(ae8),    32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Pointer wrap on DEPTH=5: 3 writes / 3 reads, four rounds.
        reset_pulse();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1, 0, 16'(r * 16 + i + 1));
                exp_q.push_back(16'(r * 16 + i + 1));
                chk($sformatf("t3_r%0d_wcount%0d", r, i), 32'(count5), 32'(i + 1));
            end
            for (int i = 0; i < 3; i++) begin
                drive(0, 1, 16'h0000);
                chk($sformatf("t3_r%0d_dout%0d", r, i), 32'(dout5), 32'(exp_q.pop_front()));
                chk($sformatf("t3_r%0d_rcount%0d", r, i), 32'(count5), 32'(2 - i));
            end
        end
        for (int i = 0; i < 6; i++) drive(1, 0, 16'h0100 + 16'(i));
        chk("t3_full",  32'(full5),  32'd1);
        chk("t3_count", 32'(count5), 32'd5);
        chk("t3_ov",    32'(ov5),    32'd1);
        drive(0, 1, 16'h0000);
        chk("t3_head",  32'(dout5),  32'h0100);

        // First-word-fall-through.
        reset_pulse();
        drive(1, 0, 16'hA5A5);
        chk("t6_dout",  32'(doutf),  32'hA5A5);
        chk("t6_empty", 32'(emptyf), 32'd0);
        drive(0, 1, 16'h0000);
        chk("t6_empty_after_rd", 32'(emptyf), 32'd1);
        drive(0, 1, 16'h0000);
        chk("t6_un", 32'(unf), 32'd1);
        drive(1, 0, 16'h1111);
        drive(1, 0, 16'h2222);
        chk("t6_head1",  32'(doutf),  32'h1111);
        chk("t6_count2", 32'(countf), 32'd2);
        drive(0, 1, 16'h0000);
        chk("t6_head2",  32'(doutf),  32'h2222);
        chk("t6_count1", 32'(countf), 32'd1);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
